// File: rtl/cart_mbc1_if.sv
// CPU-side cartridge bus as seen by the cartridge: address, write data,
// read data and the rd/wr/cs controls.
interface cart_mbc1_if;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        wr;
    logic        rd;
    logic        cs;

    modport master (output a, din, wr, rd, cs, input dout);
    modport slave  (input a, din, wr, rd, cs, output dout);
endinterface

// File: rtl/cart_mbc1.sv
// MBC1 cartridge bank controller: decodes banking register writes, maps
// CPU addresses onto banked ROM/RAM, registers read data and RAM strobes.
module cart_mbc1 #(
    parameter int ROM_ADDR_BITS = 21,
    parameter int RAM_ADDR_BITS = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cart_mbc1_if.slave               bus,
    output logic [ROM_ADDR_BITS-1:0] rom_a,
    input  logic [7:0]               rom_d,
    output logic [RAM_ADDR_BITS-1:0] ram_a,
    output logic [7:0]               ram_din,
    input  logic [7:0]               ram_dout,
    output logic                     ram_we
);

    logic       wr_q;
    logic       wr_edge;
    logic       ram_en;
    logic [4:0] rom_bank;
    logic [1:0] bank2;
    logic       mode;
    logic [4:0] bank_lo;
    logic [1:0] hi_bank;
    logic       in_ram;
    logic       rd_active;
    logic [20:0] rom_full;
    logic [14:0] ram_full;
    logic [7:0]  rd_data;

    assign wr_edge   = bus.cs & bus.wr & ~wr_q;
    assign in_ram    = (bus.a[15:13] == 3'b101);
    assign rd_active = bus.cs & bus.rd & ~bus.wr;
    assign bank_lo   = (rom_bank == 5'd0) ? 5'd1 : rom_bank;
    assign hi_bank   = mode ? bank2 : 2'b00;

    always_comb begin
        rom_full = {hi_bank, 5'd0, bus.a[13:0]};
        if (bus.a[14]) begin
            rom_full = {bank2, bank_lo, bus.a[13:0]};
        end
        ram_full = {hi_bank, bus.a[12:0]};
        rd_data  = 8'hFF;
        if (!bus.a[15]) begin
            rd_data = rom_d;
        end else if (in_ram && ram_en) begin
            rd_data = ram_dout;
        end
    end

    assign rom_a = rom_full[ROM_ADDR_BITS-1:0];
    assign ram_a = ram_full[RAM_ADDR_BITS-1:0];

    // wr_q resets high so a write already asserted at reset release never commits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q     <= 1'b1;
            ram_en   <= 1'b0;
            rom_bank <= 5'd0;
            bank2    <= 2'd0;
            mode     <= 1'b0;
        end else begin
            wr_q <= bus.cs & bus.wr;
            if (wr_edge && !bus.a[15]) begin
                unique case (bus.a[14:13])
                    2'd0: ram_en   <= (bus.din[3:0] == 4'hA);
                    2'd1: rom_bank <= bus.din[4:0];
                    2'd2: bank2    <= bus.din[1:0];
                    2'd3: mode     <= bus.din[0];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_din  <= 8'h00;
            bus.dout <= 8'hFF;
        end else begin
            ram_we <= 1'b0;
            if (wr_edge && in_ram && ram_en) begin
                ram_we  <= 1'b1;
                ram_din <= bus.din;
            end
            if (rd_active) begin
                bus.dout <= rd_data;
            end
        end
    end

endmodule
